// File: rtl/genius_engine_if.sv
// Player-facing bundle of the Genius game core: settings, buttons and status.
// The board or bench drives the master side and the engine takes the slave side.
interface genius_engine_if #(
   parameter int NUM_COLORS = 4,
   parameter int MAX_LEN    = 32
);
   localparam int AW = $clog2(MAX_LEN);

   logic                  start;
   logic                  mode;
   logic [1:0]            difficulty;
   logic                  speed;
   logic [NUM_COLORS-1:0] btn;
   logic [NUM_COLORS-1:0] led;
   logic [AW:0]           score;
   logic                  busy;
   logic                  win;
   logic                  game_over;

   modport master (
      output start, mode, difficulty, speed, btn,
      input  led, score, busy, win, game_over
   );

   modport slave (
      input  start, mode, difficulty, speed, btn,
      output led, score, busy, win, game_over
   );
endinterface

// File: rtl/genius_engine.sv
// Simon/Genius game core: LFSR or player-built sequence, timed LED playback,
// press checking against the stored sequence, scoring, timeout and win/lose flags.
module genius_engine #(
   parameter int NUM_COLORS  = 4,
   parameter int MAX_LEN     = 32,
   parameter int FAST_CYC    = 25_000_000,
   parameter int SLOW_CYC    = 50_000_000,
   parameter int TIMEOUT_CYC = 250_000_000
) (
   input  logic            clk,
   input  logic            rst_n,
   genius_engine_if.slave  bus
);
   localparam int CW     = $clog2(NUM_COLORS);
   localparam int AW     = $clog2(MAX_LEN);
   localparam int MAXCYC = (FAST_CYC > SLOW_CYC) ?
                           ((FAST_CYC > TIMEOUT_CYC) ? FAST_CYC : TIMEOUT_CYC) :
                           ((SLOW_CYC > TIMEOUT_CYC) ? SLOW_CYC : TIMEOUT_CYC);
   localparam int TW     = $clog2(MAXCYC) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_GEN, S_ADD, S_PLAY_ON, S_PLAY_OFF, S_WAIT_IN, S_WIN, S_LOSE
   } state_t;

   function automatic logic [NUM_COLORS-1:0] f_onehot(input logic [CW-1:0] c);
      return NUM_COLORS'(1) << c;
   endfunction

   function automatic logic [CW-1:0] f_encode(input logic [NUM_COLORS-1:0] p);
      logic [CW-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_COLORS; i++)
         if (p[i]) idx = CW'(i);
      return idx;
   endfunction

   function automatic logic f_is_onehot(input logic [NUM_COLORS-1:0] p);
      return (p != '0) && ((p & (p - 1'b1)) == '0);
   endfunction

   // Target lengths beyond the RAM depth collapse onto MAX_LEN.
   function automatic logic [AW:0] f_target(input logic [1:0] d);
      int t;
      case (d)
         2'd0:    t = 8;
         2'd1:    t = 16;
         2'd2:    t = 32;
         default: t = MAX_LEN;
      endcase
      if (t > MAX_LEN) t = MAX_LEN;
      return t[AW:0];
   endfunction

   state_t                r_state;
   state_t                w_next;
   logic                  r_start_q;
   logic [NUM_COLORS-1:0] r_btn_q;
   logic [15:0]           r_lfsr;
   logic                  r_mode;
   logic                  r_speed;
   logic [AW:0]           r_target;
   logic [AW:0]           r_len;
   logic [AW:0]           r_score;
   logic [AW-1:0]         r_pidx;
   logic [AW-1:0]         r_midx;
   logic [TW-1:0]         r_timer;
   logic [CW-1:0]         r_ram [MAX_LEN];

   logic                  w_start_edge;
   logic                  w_in_state;
   logic [NUM_COLORS-1:0] w_press;
   logic                  w_press_one;
   logic [CW-1:0]         w_press_idx;
   logic [CW-1:0]         w_play_item;
   logic [CW-1:0]         w_exp_item;
   logic                  w_match;
   logic [AW:0]           w_last_idx;
   logic                  w_play_last;
   logic                  w_match_last;
   logic [TW-1:0]         w_t_cyc;
   logic                  w_t_last;
   logic                  w_timeout;
   logic [15:0]           w_lfsr_nxt;
   logic [NUM_COLORS-1:0] w_led;
   logic                  w_busy;
   logic                  w_win;
   logic                  w_lose;

   assign w_start_edge = bus.start & ~r_start_q;
   assign w_in_state   = (r_state == S_ADD) || (r_state == S_WAIT_IN);
   assign w_press      = w_in_state ? (bus.btn & ~r_btn_q) : '0;
   assign w_press_one  = f_is_onehot(w_press);
   assign w_press_idx  = f_encode(w_press);
   assign w_play_item  = r_ram[r_pidx];
   assign w_exp_item   = r_ram[r_midx];
   assign w_match      = w_press_one && (w_press_idx == w_exp_item);
   assign w_last_idx   = r_len - (AW+1)'(1);
   assign w_play_last  = ({1'b0, r_pidx} == w_last_idx);
   assign w_match_last = ({1'b0, r_midx} == w_last_idx);
   assign w_t_cyc      = r_speed ? TW'(FAST_CYC) : TW'(SLOW_CYC);
   assign w_t_last     = (r_timer == w_t_cyc - TW'(1));
   assign w_timeout    = (w_press == '0) && (r_timer == TW'(TIMEOUT_CYC - 1));
   // Taps 16,14,13,11 in right-shift form; the lock-up state is escaped to the seed.
   assign w_lfsr_nxt   = (r_lfsr == 16'h0000) ? 16'hACE1 :
                         {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_WIN, S_LOSE:
            if (w_start_edge) w_next = bus.mode ? S_ADD : S_GEN;
         S_GEN:
            w_next = S_PLAY_ON;
         S_ADD:
            if (w_press_one)    w_next = S_PLAY_ON;
            else if (w_timeout) w_next = S_LOSE;
         S_PLAY_ON:
            if (w_t_last) w_next = S_PLAY_OFF;
         S_PLAY_OFF:
            if (w_t_last) w_next = w_play_last ? S_WAIT_IN : S_PLAY_ON;
         S_WAIT_IN:
            if (w_press != '0) begin
               if (!w_match)
                  w_next = S_LOSE;
               else if (w_match_last)
                  w_next = (r_len == r_target) ? S_WIN : (r_mode ? S_ADD : S_GEN);
            end else if (w_timeout) begin
               w_next = S_LOSE;
            end
         default:
            w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_led  = '0;
      w_busy = 1'b1;
      w_win  = 1'b0;
      w_lose = 1'b0;
      case (r_state)
         S_IDLE:              w_busy = 1'b0;
         S_WIN:               begin w_busy = 1'b0; w_win = 1'b1; w_led = '1; end
         S_LOSE:              begin w_busy = 1'b0; w_lose = 1'b1; end
         S_ADD, S_WAIT_IN:    w_led = bus.btn;
         S_PLAY_ON:           w_led = f_onehot(w_play_item);
         default:             ;
      endcase
   end

   assign bus.led       = w_led;
   assign bus.busy      = w_busy;
   assign bus.win       = w_win;
   assign bus.game_over = w_lose;
   assign bus.score     = r_score;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_q <= 1'b0;
         r_btn_q   <= '0;
         r_lfsr    <= 16'hACE1;
         r_mode    <= 1'b0;
         r_speed   <= 1'b0;
         r_target  <= '0;
         r_len     <= '0;
         r_score   <= '0;
         r_pidx    <= '0;
         r_midx    <= '0;
         r_timer   <= '0;
      end else begin
         r_start_q <= bus.start;
         r_btn_q   <= bus.btn;
         r_lfsr    <= w_lfsr_nxt;
         // Every phase starts from zero; any press restarts the input window.
         if ((w_next != r_state) || (w_press != '0)) r_timer <= '0;
         else if (w_busy)                            r_timer <= r_timer + TW'(1);
         else                                        r_timer <= '0;
         case (r_state)
            S_IDLE, S_WIN, S_LOSE:
               if (w_start_edge) begin
                  r_mode   <= bus.mode;
                  r_speed  <= bus.speed;
                  r_target <= f_target(bus.difficulty);
                  r_len    <= '0;
                  r_score  <= '0;
               end
            S_GEN: begin
               r_len  <= r_len + (AW+1)'(1);
               r_pidx <= '0;
            end
            S_ADD:
               if (w_press_one) begin
                  r_len  <= r_len + (AW+1)'(1);
                  r_pidx <= '0;
               end
            S_PLAY_OFF:
               if (w_t_last) begin
                  if (w_play_last) r_midx <= '0;
                  else             r_pidx <= r_pidx + AW'(1);
               end
            S_WAIT_IN:
               if (w_match) begin
                  if (!w_match_last)
                     r_midx <= r_midx + AW'(1);
                  else if (r_score != (AW+1)'(MAX_LEN))
                     r_score <= r_score + (AW+1)'(1);
               end
            default: ;
         endcase
      end
   end

   // Sequence storage holds no reset; r_len alone marks the valid entries.
   always_ff @(posedge clk) begin
      if (r_state == S_GEN)
         r_ram[r_len[AW-1:0]] <= r_lfsr[CW-1:0];
      else if ((r_state == S_ADD) && w_press_one)
         r_ram[r_len[AW-1:0]] <= w_press_idx;
   end
endmodule

// File: tb/tb_genius_engine.sv
// Bench for genius_engine: a 4-colour/32-step core and an 8-colour/64-step core
// share stimulus through a selector; expected LED streams go through a scoreboard queue.
module tb_genius_engine;
  localparam int FAST = 4;
  localparam int SLOW = 8;
  localparam int TO   = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  genius_engine_if #(.NUM_COLORS(4), .MAX_LEN(32)) if4 ();
  genius_engine_if #(.NUM_COLORS(8), .MAX_LEN(64)) if8 ();

  genius_engine #(.NUM_COLORS(4), .MAX_LEN(32), .FAST_CYC(FAST), .SLOW_CYC(SLOW),
                  .TIMEOUT_CYC(TO)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  genius_engine #(.NUM_COLORS(8), .MAX_LEN(64), .FAST_CYC(FAST), .SLOW_CYC(SLOW),
                  .TIMEOUT_CYC(TO)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  logic       sel = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       speed = 1'b1;
  logic [1:0] diff = 2'd0;
  logic [7:0] btn = 8'h00;

  assign if4.start      = start & ~sel;
  assign if4.mode       = mode;
  assign if4.difficulty = diff;
  assign if4.speed      = speed;
  assign if4.btn        = sel ? 4'b0000 : btn[3:0];
  assign if8.start      = start & sel;
  assign if8.mode       = mode;
  assign if8.difficulty = diff;
  assign if8.speed      = speed;
  assign if8.btn        = sel ? btn : 8'h00;

  wire [7:0] led_s   = sel ? if8.led : {4'b0000, if4.led};
  wire [6:0] score_s = sel ? if8.score : {1'b0, if4.score};
  wire       busy_s  = sel ? if8.busy : if4.busy;
  wire       win_s   = sel ? if8.win : if4.win;
  wire       go_s    = sel ? if8.game_over : if4.game_over;

  // Reference item source: x^16+x^14+x^13+x^11, seed ACE1, one step per clock.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                m_lfsr <= 16'hACE1;
    else if (m_lfsr == 16'h0)  m_lfsr <= 16'hACE1;
    else                       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  int n_vec = 0;
  int n_err = 0;
  int seq [64];
  int len_m = 0;
  logic [7:0] exp_q [$];

  function automatic logic [7:0] oh(input int c);
    return 8'd1 << c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic m, input logic [1:0] d, input logic s);
    mode = m; diff = d; speed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    len_m = 0;
    n_vec++;
    if ({busy_s, win_s, go_s, score_s} !== {3'b100, 7'd0}) begin
      n_err++;
      $display("FAIL start_state: busy/win/go/score=%b/%b/%b/%0d want 1/0/0/0", busy_s, win_s, go_s, score_s);
    end
  endtask

  task automatic gen_item();
    seq[len_m] = int'(m_lfsr) & (sel ? 7 : 3);
    len_m++;
  endtask

  // Entered on the first PLAY_ON cycle, returns on the first WAIT_IN cycle.
  task automatic playback(input int T, input bit pulse);
    for (int i = 0; i < len_m; i++) begin
      repeat (T) exp_q.push_back(oh(seq[i]));
      repeat (T) exp_q.push_back(8'h00);
    end
    for (int k = 0; k < 2 * T * len_m; k++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if (led_s !== e) begin
        n_err++;
        $display("FAIL playback len=%0d cyc=%0d: led=%b want %b", len_m, k, led_s, e);
      end
      if (pulse && k == 1) start = 1'b1;
      if (pulse && k == 3) start = 1'b0;
      tick();
    end
  endtask

  task automatic replay(input int n);
    for (int i = 0; i < n; i++) begin
      btn = oh(seq[i]);
      tick();
      btn = 8'h00;
      if (i < n - 1) tick();
    end
  endtask

  task automatic follow_round(input int T, input bit pulse);
    gen_item();
    tick();
    playback(T, pulse);
    replay(len_m);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({led_s, busy_s, win_s, go_s, score_s} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_idle: led=%b busy=%b win=%b go=%b score=%0d want all 0", led_s, busy_s, win_s, go_s, score_s);
    end
    start_game(1'b0, 2'd0, 1'b1);
    follow_round(FAST, 1'b0);
    n_vec++;
    if (score_s !== 7'd1) begin n_err++; $display("FAIL reset_pre_score: score=%0d want 1", score_s); end
    gen_item();
    tick();
    tick();
    n_vec++;
    if ({busy_s, led_s} !== {1'b1, oh(seq[0])}) begin
      n_err++;
      $display("FAIL reset_pre_play: busy=%b led=%b want 1 %b", busy_s, led_s, oh(seq[0]));
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({led_s, busy_s, score_s} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_async: led=%b busy=%b score=%0d want 0 0 0", led_s, busy_s, score_s);
    end
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    n_vec++;
    if ({led_s, busy_s, win_s, go_s, score_s} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_after: led=%b busy=%b win=%b go=%b score=%0d want all 0", led_s, busy_s, win_s, go_s, score_s);
    end
  endtask

  task automatic test_follow_win();
    start_game(1'b0, 2'd0, 1'b1);
    for (int r = 1; r <= 8; r++) begin
      follow_round(FAST, 1'b0);
      n_vec++;
      if (score_s !== 7'(r)) begin n_err++; $display("FAIL follow_score: score=%0d want %0d", score_s, r); end
    end
    n_vec++;
    if ({win_s, go_s, busy_s, led_s} !== {3'b100, 8'h0F}) begin
      n_err++;
      $display("FAIL follow_win: win=%b go=%b busy=%b led=%b want 1 0 0 00001111", win_s, go_s, busy_s, led_s);
    end
    btn = 8'h02;
    tick();
    btn = 8'h00;
    tick();
    n_vec++;
    if ({win_s, led_s, score_s} !== {1'b1, 8'h0F, 7'd8}) begin
      n_err++;
      $display("FAIL win_hold: win=%b led=%b score=%0d want 1 00001111 8", win_s, led_s, score_s);
    end
  endtask

  task automatic test_wrong_press();
    start_game(1'b0, 2'd0, 1'b1);
    follow_round(FAST, 1'b0);
    follow_round(FAST, 1'b0);
    gen_item();
    tick();
    playback(FAST, 1'b0);
    btn = oh(seq[0]);
    tick();
    btn = 8'h00;
    tick();
    btn = oh((seq[1] + 1) % 4);
    tick();
    btn = 8'h00;
    n_vec++;
    if ({go_s, win_s, busy_s, led_s, score_s} !== {3'b100, 8'h00, 7'd2}) begin
      n_err++;
      $display("FAIL wrong_lose: go=%b win=%b busy=%b led=%b score=%0d want 1 0 0 0 2", go_s, win_s, busy_s, led_s, score_s);
    end
  endtask

  task automatic test_timeout();
    start_game(1'b0, 2'd0, 1'b1);
    follow_round(FAST, 1'b0);
    gen_item();
    tick();
    playback(FAST, 1'b0);
    repeat (63) tick();
    n_vec++;
    if ({busy_s, go_s} !== 2'b10) begin n_err++; $display("FAIL timeout_early: busy=%b go=%b want 1 0", busy_s, go_s); end
    btn = oh(seq[0]);
    tick();
    btn = 8'h00;
    n_vec++;
    if ({busy_s, go_s} !== 2'b10) begin n_err++; $display("FAIL timeout_press63: busy=%b go=%b want 1 0", busy_s, go_s); end
    repeat (63) tick();
    n_vec++;
    if ({busy_s, go_s} !== 2'b10) begin n_err++; $display("FAIL timeout_restart: busy=%b go=%b want 1 0", busy_s, go_s); end
    tick();
    n_vec++;
    if ({go_s, busy_s, led_s, score_s} !== {2'b10, 8'h00, 7'd1}) begin
      n_err++;
      $display("FAIL timeout_lose: go=%b busy=%b led=%b score=%0d want 1 0 0 1", go_s, busy_s, led_s, score_s);
    end
  endtask

  task automatic test_command();
    start_game(1'b1, 2'd0, 1'b0);
    btn = 8'h05;
    #1;
    n_vec++;
    if (led_s !== 8'h05) begin n_err++; $display("FAIL add_mirror: led=%b want 00000101", led_s); end
    tick();
    btn = 8'h00;
    tick();
    n_vec++;
    if ({busy_s, led_s} !== {1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL add_multi_ignored: busy=%b led=%b want 1 0", busy_s, led_s);
    end
    seq[0] = 2;
    len_m = 1;
    btn = 8'h04;
    tick();
    btn = 8'h00;
    playback(SLOW, 1'b0);
    btn = 8'h05;
    tick();
    btn = 8'h00;
    n_vec++;
    if ({go_s, busy_s, led_s, score_s} !== {2'b10, 8'h00, 7'd0}) begin
      n_err++;
      $display("FAIL cmd_multi_lose: go=%b busy=%b led=%b score=%0d want 1 0 0 0", go_s, busy_s, led_s, score_s);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    tick();
    start_game(1'b0, 2'd3, 1'b1);
    for (int r = 1; r <= 64; r++) begin
      follow_round(FAST, r == 2);
      n_vec++;
      if (score_s !== 7'(r)) begin n_err++; $display("FAIL wide_score: score=%0d want %0d", score_s, r); end
    end
    n_vec++;
    if ({win_s, go_s, busy_s, led_s, score_s} !== {3'b100, 8'hFF, 7'd64}) begin
      n_err++;
      $display("FAIL wide_win: win=%b go=%b busy=%b led=%b score=%0d want 1 0 0 11111111 64", win_s, go_s, busy_s, led_s, score_s);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_follow_win();
    test_wrong_press();
    test_timeout();
    test_command();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
